// File: rtl/adder_operand_packer.sv
`timescale 1ns/1ps
// adder_operand_packer
// Collects a serial stream of BITS-wide operands into NUM-lane groups and
// issues each group to the multi-input adder as a one-cycle valid pulse.
// Issue is credit-limited so at most MAX_OUT sums are in flight; the adder's
// valid_out returns credits. Operands are opaque here (float16 bit patterns),
// so no arithmetic is applied to them.
module adder_operand_packer #(
  parameter int BITS    = 16,
  parameter int NUM     = 4,
  parameter int MAX_OUT = 4,
  localparam int CW     = $clog2(MAX_OUT + 1),
  localparam int FW     = (NUM > 1) ? $clog2(NUM) : 1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BITS-1:0]     in_data,
  input  logic                in_last,
  input  logic                ret_valid,
  output logic                valid,
  output logic [NUM*BITS-1:0] data,
  output logic [CW-1:0]       credits,
  output logic                err_overflow
);

  // Credit counter update: a take consumes one credit, a return restores one,
  // both together cancel. A return at full credit saturates instead of wrapping.
  function automatic logic [CW-1:0] next_credit(input logic [CW-1:0] cur,
                                                input logic            take,
                                                input logic            ret);
    logic [CW-1:0] nxt;
    nxt = cur;
    if (take && !ret) begin
      nxt = cur - CW'(1);
    end else if (ret && !take && (cur != CW'(MAX_OUT))) begin
      nxt = cur + CW'(1);
    end
    return nxt;
  endfunction

  // A return with nothing outstanding indicates a protocol error downstream.
  function automatic logic is_overflow(input logic [CW-1:0] cur,
                                       input logic            take,
                                       input logic            ret);
    return ret && !take && (cur == CW'(MAX_OUT));
  endfunction

  logic [FW-1:0]       fill_p0;
  logic [NUM*BITS-1:0] lanes_p0;
  logic                vld_p1;
  logic [NUM*BITS-1:0] data_p1;
  logic [CW-1:0]       credits_q;
  logic                err_q;

  logic                accept;
  logic                final_acc;
  logic [NUM*BITS-1:0] packed_w;

  // in_ready depends only on registered credit state, never on in_valid.
  assign in_ready  = (credits_q != '0);
  assign accept    = in_valid && in_ready;
  assign final_acc = accept && (in_last || (fill_p0 == FW'(NUM - 1)));

  // Lane image including the operand being accepted this cycle; lane 0 sits
  // in the MSBs so the adder sees {i0, i1, ...} = data.
  always_comb begin
    packed_w = lanes_p0;
    if (accept) begin
      packed_w[(NUM - 1 - int'(fill_p0)) * BITS +: BITS] = in_data;
    end
  end

  // Stage 0: lane fill. A completed group clears the lanes so unfilled lanes
  // of the next short group read as +0.0.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fill_p0  <= '0;
      lanes_p0 <= '0;
    end else if (accept) begin
      if (final_acc) begin
        fill_p0  <= '0;
        lanes_p0 <= '0;
      end else begin
        fill_p0  <= fill_p0 + FW'(1);
        lanes_p0 <= packed_w;
      end
    end
  end

  // Stage 1: issue register. data holds between pulses; valid is one cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= final_acc;
      if (final_acc) begin
        data_p1 <= packed_w;
      end
    end
  end

  // Credit accounting and sticky overflow flag, updated on the issue edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      credits_q <= CW'(MAX_OUT);
      err_q     <= 1'b0;
    end else begin
      credits_q <= next_credit(credits_q, final_acc, ret_valid);
      if (is_overflow(credits_q, final_acc, ret_valid)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign valid        = vld_p1;
  assign data         = data_p1;
  assign credits      = credits_q;
  assign err_overflow = err_q;

endmodule

// File: tb/tb_adder_operand_packer.sv
`timescale 1ns/1ps
// Testbench for adder_operand_packer: directed scenarios followed by a
// randomized stream, with a scoreboard fed by a group-level reference model.
module tb_adder_operand_packer;

  localparam int BITS    = 16;
  localparam int NUM     = 4;
  localparam int MAX_OUT = 4;
  localparam int CW      = $clog2(MAX_OUT + 1);

  logic                clk = 1'b0;
  logic                resetn = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [BITS-1:0]     in_data = '0;
  logic                in_last = 1'b0;
  logic                ret_valid = 1'b0;
  logic                valid;
  logic [NUM*BITS-1:0] data;
  logic [CW-1:0]       credits;
  logic                err_overflow;

  adder_operand_packer #(.BITS(BITS), .NUM(NUM), .MAX_OUT(MAX_OUT)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .ret_valid    (ret_valid),
    .valid        (valid),
    .data         (data),
    .credits      (credits),
    .err_overflow (err_overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [NUM*BITS-1:0] word;
    int                  due;
  } exp_t;

  exp_t            expq[$];
  logic [BITS-1:0] grp[$];
  int              m_credits = MAX_OUT;
  bit              m_err = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: groups operands in a queue, predicts issue words,
  // credit count and overflow flag from the handshake seen each cycle.
  always @(negedge clk) begin
    bit take;
    logic [NUM*BITS-1:0] w;
    if (!resetn) begin
      m_credits = MAX_OUT;
      m_err     = 1'b0;
      grp.delete();
      expq.delete();
    end else begin
      chk("credits", 64'(credits), 64'(m_credits));
      chk("in_ready", 64'(in_ready), 64'(m_credits != 0));
      chk("err_overflow", 64'(err_overflow), 64'(m_err));
      take = 1'b0;
      if (in_valid && m_credits != 0) begin
        grp.push_back(in_data);
        if (in_last || grp.size() == NUM) begin
          w = '0;
          for (int i = 0; i < NUM; i++) begin
            w = (w << BITS) | ((i < grp.size()) ? (NUM*BITS)'(grp[i]) : '0);
          end
          expq.push_back('{w, cyc + 1});
          grp.delete();
          take = 1'b1;
        end
      end
      if (ret_valid && !take && m_credits == MAX_OUT) m_err = 1'b1;
      if (take && !ret_valid) m_credits--;
      else if (!take && ret_valid && m_credits < MAX_OUT) m_credits++;
    end
  end

  // Monitor: every valid pulse must match the oldest predicted group, on time.
  always @(negedge clk) begin
    exp_t e;
    if (resetn) begin
      if (valid) begin
        if (expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_valid: got data %h expected no issue (cycle %0d)", data, cyc);
        end else begin
          e = expq.pop_front();
          chk("group_data", 64'(data), 64'(e.word));
          chk("group_latency", 64'(cyc), 64'(e.due));
        end
      end else if (expq.size() > 0 && expq[0].due <= cyc) begin
        e = expq.pop_front();
        checks++; errors++;
        $display("FAIL missing_valid: got valid 0 expected data %h (cycle %0d)", e.word, cyc);
      end
    end
  end

  task automatic step(input logic v, input logic [BITS-1:0] d, input logic l, input logic r);
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    ret_valid = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic            nv, nl, nr, will_acc;
    logic [BITS-1:0] nd;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", 64'(valid), 64'(0));
    chk("reset_data", 64'(data), 64'(0));
    chk("reset_credits", 64'(credits), 64'(MAX_OUT));
    chk("reset_err", 64'(err_overflow), 64'(0));
    @(negedge clk);
    #2 resetn = 1'b1;
    @(posedge clk);
    #1;

    // Basic full group
    step(1, 16'h36ac, 0, 0);
    step(1, 16'h39c3, 0, 0);
    step(1, 16'h077f, 0, 0);
    step(1, 16'h34d6, 0, 0);
    chk("basic_valid", 64'(valid), 64'(1));
    chk("basic_data", 64'(data), 64'h36ac_39c3_077f_34d6);
    chk("basic_credits", 64'(credits), 64'(3));

    // Short group, then the next operand must land in lane 0
    step(1, 16'h3c00, 0, 0);
    step(1, 16'h4000, 1, 0);
    chk("short_valid", 64'(valid), 64'(1));
    chk("short_data", 64'(data), 64'h3c00_4000_0000_0000);
    step(1, 16'h3555, 0, 0);
    chk("short_no_issue", 64'(valid), 64'(0));
    step(1, 16'h1111, 1, 0);
    chk("lane0_data", 64'(data), 64'h3555_1111_0000_0000);
    chk("lane0_credits", 64'(credits), 64'(1));
    repeat (3) step(0, '0, 0, 1);
    chk("refill_credits", 64'(credits), 64'(MAX_OUT));

    // Credit exhaustion
    for (int i = 0; i < 4; i++) step(1, BITS'(16'h0100 + i), 1, 0);
    chk("exhaust_credits", 64'(credits), 64'(0));
    chk("exhaust_ready", 64'(in_ready), 64'(0));
    for (int i = 0; i < 20; i++) begin
      step(1, 16'h1234, 1, 0);
      chk("held_ready", 64'(in_ready), 64'(0));
    end
    step(1, 16'h1234, 1, 1);
    chk("return_credits", 64'(credits), 64'(1));
    chk("return_ready", 64'(in_ready), 64'(1));
    step(1, 16'h1234, 1, 0);
    chk("held_data", 64'(data), 64'h1234_0000_0000_0000);
    chk("held_credits", 64'(credits), 64'(0));
    repeat (2) step(0, '0, 0, 1);

    // Simultaneous take and return
    chk("pre_simul_credits", 64'(credits), 64'(2));
    step(1, 16'h4242, 1, 1);
    chk("simul_credits", 64'(credits), 64'(2));
    chk("simul_valid", 64'(valid), 64'(1));
    chk("simul_data", 64'(data), 64'h4242_0000_0000_0000);
    repeat (2) step(0, '0, 0, 1);

    // Spurious return
    step(0, '0, 0, 1);
    chk("spur_credits", 64'(credits), 64'(MAX_OUT));
    chk("spur_err", 64'(err_overflow), 64'(1));
    step(1, 16'h5001, 0, 0);
    step(1, 16'h5002, 0, 0);
    step(1, 16'h5003, 0, 0);
    step(1, 16'h5004, 0, 0);
    chk("spur_err_held", 64'(err_overflow), 64'(1));
    chk("spur_group_credits", 64'(credits), 64'(3));
    step(0, '0, 0, 0);

    // Reset mid-group, asserted between clock edges
    step(1, 16'haaaa, 0, 0);
    step(1, 16'hbbbb, 0, 0);
    step(0, '0, 0, 0);
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("async_valid", 64'(valid), 64'(0));
    chk("async_data", 64'(data), 64'(0));
    chk("async_credits", 64'(credits), 64'(MAX_OUT));
    chk("async_err", 64'(err_overflow), 64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 resetn = 1'b1;
    @(posedge clk);
    #1;
    step(1, 16'h1001, 0, 0);
    step(1, 16'h1002, 0, 0);
    step(1, 16'h1003, 0, 0);
    step(1, 16'h1004, 0, 0);
    chk("post_reset_data", 64'(data), 64'h1001_1002_1003_1004);
    chk("post_reset_credits", 64'(credits), 64'(3));

    // Randomized stream; the source holds an operand until it is accepted
    will_acc = 1'b0;
    nv = 1'b0; nd = '0; nl = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!in_valid || will_acc) begin
        nv = ($urandom_range(0, 9) < 7);
        nd = BITS'($urandom);
        nl = ($urandom_range(0, 4) == 0);
      end else begin
        nv = in_valid; nd = in_data; nl = in_last;
      end
      nr = (m_credits < MAX_OUT) && ($urandom_range(0, 2) == 0);
      in_valid = nv; in_data = nd; in_last = nl; ret_valid = nr;
      will_acc = nv && in_ready;
      @(posedge clk);
      #1;
    end
    repeat (5) step(0, '0, 0, 0);
    chk("scoreboard_drained", 64'(expq.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
